// File: rtl/pushbutton_debounce_if.sv
// Signal bundle for pushbutton_debounce: raw button and divider strobe in,
// debounced level and press/release pulses out.
interface pushbutton_debounce_if;
  logic btn_in;
  logic clk_slow;
  logic db_level;
  logic db_pulse;
  logic db_release;

  modport master (
    output btn_in, clk_slow,
    input  db_level, db_pulse, db_release
  );

  modport slave (
    input  btn_in, clk_slow,
    output db_level, db_pulse, db_release
  );
endinterface

// File: rtl/pushbutton_debounce.sv
// Pushbutton debouncer sampled by the synchronised 500 Hz divider strobe.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while held.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RELEASED | button up; waiting for SAMPLES consecutive 1 samples
// PRESSED  | button down; waiting for SAMPLES consecutive 0 samples
module pushbutton_debounce #(
  parameter int SAMPLES      = 4,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 50
) (
  input logic                  clk_in,
  input logic                  reset,
  pushbutton_debounce_if.slave bus
);

  if (SAMPLES < 2 || SAMPLES > 16 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 65535) begin : g_bad_param
    $error("pushbutton_debounce: parameter out of range");
  end

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         btn_sync_q, btn_sync_d;
  logic [1:0]         slow_sync_q, slow_sync_d;
  logic               slow_q, slow_d;
  logic [SAMPLES-2:0] shreg_q, shreg_d;
  logic               pulse_q, pulse_d;
  logic               release_q, release_d;

  logic               btn_s, slow_s, tick;
  logic [SAMPLES-1:0] window;
  logic               win_ones, win_zeros;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [15:0] DELAY_C  = 16'(REPEAT_DELAY);
  // A rate not shorter than the delay degenerates to one repeat per delay period.
  localparam logic [15:0] RELOAD_C = (REPEAT_RATE >= REPEAT_DELAY) ? 16'd0
                                     : 16'(REPEAT_DELAY - REPEAT_RATE);
  logic [15:0] cnt_q, cnt_d, cnt_inc;
`endif

  assign btn_s     = btn_sync_q[1];
  assign slow_s    = slow_sync_q[1];
  assign tick      = slow_s & ~slow_q;
  assign window    = {shreg_q, btn_s};
  assign win_ones  = &window;
  assign win_zeros = ~|window;

  always_comb begin
    btn_sync_d  = {btn_sync_q[0], bus.btn_in};
    slow_sync_d = {slow_sync_q[0], bus.clk_slow};
    slow_d      = slow_s;
    shreg_d     = shreg_q;
    state_d     = state_q;
    pulse_d     = 1'b0;
    release_d   = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    cnt_d       = cnt_q;
    cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif
    if (tick) begin
      shreg_d = window[SAMPLES-2:0];
      case (state_q)
        RELEASED: begin
          if (win_ones) begin
            state_d = PRESSED;
            pulse_d = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
            cnt_d   = 16'd0;
`endif
          end
        end
        PRESSED: begin
          if (win_zeros) begin
            state_d   = RELEASED;
            release_d = 1'b1;
          end else begin
`ifdef DEBOUNCE_REPEAT_EN
            if (cnt_inc == DELAY_C) begin
              pulse_d = 1'b1;
              cnt_d   = RELOAD_C;
            end else begin
              cnt_d   = cnt_inc;
            end
`endif
          end
        end
        default: state_d = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= RELEASED;
      btn_sync_q  <= '0;
      slow_sync_q <= '0;
      slow_q      <= 1'b0;
      shreg_q     <= '0;
      pulse_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      btn_sync_q  <= btn_sync_d;
      slow_sync_q <= slow_sync_d;
      slow_q      <= slow_d;
      shreg_q     <= shreg_d;
      pulse_q     <= pulse_d;
      release_q   <= release_d;
`ifdef DEBOUNCE_REPEAT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.db_level   = (state_q == PRESSED);
  assign bus.db_pulse   = pulse_q;
  assign bus.db_release = release_q;

endmodule

// File: tb/tb_pushbutton_debounce.sv
// Bench for pushbutton_debounce: randomized button/strobe stimulus checked
// cycle by cycle against a run-length reference model, plus scenario checks.
module tb_pushbutton_debounce;
  localparam int SAMPLES = 4;
  localparam int RDELAY  = 10;
  localparam int RRATE   = 3;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  pushbutton_debounce_if bus();

  pushbutton_debounce #(
    .SAMPLES(SAMPLES), .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Strobe edges land at 2 mod 10, never on a clk_in edge; random duty cycle.
  initial begin
    bus.clk_slow = 1'b0;
    #2;
    forever begin
      #(10 * $urandom_range(8, 13));
      bus.clk_slow = ~bus.clk_slow;
    end
  end

  // Reference model: tracks the sampled button as a run length of equal
  // samples and counts held ticks since the press.
  logic m_b1, m_b2, m_s1, m_s2, m_s3, m_last, m_pressed;
  int   m_run, m_held;
  int   m_ticks = 0;
  logic exp_level, exp_pulse, exp_release;

  always @(posedge clk_in or posedge reset) begin : model_step
    int   run, held;
    logic pr, pu, rl;
    if (reset) begin
      m_b1 <= 1'b0; m_b2 <= 1'b0; m_s1 <= 1'b0; m_s2 <= 1'b0; m_s3 <= 1'b0;
      m_last <= 1'b0; m_run <= SAMPLES - 1; m_pressed <= 1'b0; m_held <= 0;
      exp_level <= 1'b0; exp_pulse <= 1'b0; exp_release <= 1'b0;
    end else begin
      run = m_run; held = m_held; pr = m_pressed; pu = 1'b0; rl = 1'b0;
      if (m_s2 && !m_s3) begin
        m_ticks <= m_ticks + 1;
        if (m_b2 == m_last) run = (run < 1000) ? run + 1 : run;
        else run = 1;
        if (!pr && m_b2 && run >= SAMPLES) begin
          pr = 1'b1; pu = 1'b1; held = 0;
        end else if (pr && !m_b2 && run >= SAMPLES) begin
          pr = 1'b0; rl = 1'b1;
        end else if (pr) begin
          held = held + 1;
`ifdef DEBOUNCE_REPEAT_EN
          if (held >= RDELAY && ((held - RDELAY) % RRATE) == 0) pu = 1'b1;
`endif
        end
        m_last <= m_b2;
      end
      m_b1 <= bus.btn_in; m_b2 <= m_b1;
      m_s1 <= bus.clk_slow; m_s2 <= m_s1; m_s3 <= m_s2;
      m_run <= run; m_held <= held; m_pressed <= pr;
      exp_level <= pr; exp_pulse <= pu; exp_release <= rl;
    end
  end

  wire [2:0] dut_o = {bus.db_level, bus.db_pulse, bus.db_release};
  wire [2:0] exp_o = {exp_level, exp_pulse, exp_release};

  task automatic test_reset;
    int t0;
    bit got;
    bus.btn_in = 1'b1;
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== 3'b000) begin
        bad++; $display("FAIL reset_hold: outputs=%b want=000", dut_o);
      end
    end
    reset = 1'b0;
    t0 = m_ticks;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== exp_o) begin
        bad++; $display("FAIL reset_cycle: outputs=%b want=%b", dut_o, exp_o);
      end
      if (bus.db_pulse) begin
        got = 1'b1;
        total++;
        if (m_ticks - t0 != SAMPLES) begin
          bad++; $display("FAIL reset_first_press: ticks=%0d want=%0d", m_ticks - t0, SAMPLES);
        end
      end
    end
    if (!got) begin
      total++; bad++; $display("FAIL reset_first_press: no pulse seen want=1");
    end
  endtask

  task automatic test_release;
    int t0, rel, pul, rel_tick;
    bus.btn_in = 1'b0;
    t0 = m_ticks; rel = 0; pul = 0; rel_tick = 0;
    for (int c = 0; c < 400 && m_ticks < t0 + SAMPLES + 3; c++) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== exp_o) begin
        bad++; $display("FAIL release_cycle: outputs=%b want=%b", dut_o, exp_o);
      end
      if (bus.db_release) begin rel++; rel_tick = m_ticks - t0; end
      if (bus.db_pulse) pul++;
    end
    total++;
    if (rel != 1 || pul != 0) begin
      bad++; $display("FAIL release_count: release=%0d pulse=%0d want=1/0", rel, pul);
    end
    total++;
    if (rel_tick < SAMPLES || rel_tick > SAMPLES + 1) begin
      bad++; $display("FAIL release_latency: ticks=%0d want=%0d..%0d", rel_tick, SAMPLES, SAMPLES + 1);
    end
    total++;
    if (bus.db_level !== 1'b0) begin
      bad++; $display("FAIL release_level: level=%b want=0", bus.db_level);
    end
  endtask

  task automatic test_bouncy_press;
    int t0, pul, rel, width, press_tick, nbounce;
    pul = 0; rel = 0; width = 0; press_tick = 0;
    nbounce = $urandom_range(30, 45);
    for (int c = 0; c < nbounce; c++) begin
      @(negedge clk_in);
      if ((c % 3) == 0) bus.btn_in = $urandom_range(0, 1);
      total++;
      if (dut_o !== exp_o) begin
        bad++; $display("FAIL bounce_cycle: outputs=%b want=%b", dut_o, exp_o);
      end
      if (bus.db_pulse) pul++;
      if (bus.db_release) rel++;
    end
    bus.btn_in = 1'b0;
    repeat (3) @(negedge clk_in);
    bus.btn_in = 1'b1;
    t0 = m_ticks;
    for (int c = 0; c < 500 && m_ticks < t0 + SAMPLES + 3; c++) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== exp_o) begin
        bad++; $display("FAIL bounce_cycle: outputs=%b want=%b", dut_o, exp_o);
      end
      if (bus.db_pulse) begin
        pul++; press_tick = m_ticks - t0;
        if (bus.db_level) width++;
      end
      if (bus.db_release) rel++;
    end
    total++;
    if (pul != 1 || rel != 0 || width != 1) begin
      bad++; $display("FAIL bounce_pulses: pulse=%0d release=%0d level_with_pulse=%0d want=1/0/1", pul, rel, width);
    end
    total++;
    if (press_tick < SAMPLES || press_tick > SAMPLES + 1) begin
      bad++; $display("FAIL bounce_latency: ticks=%0d want=%0d..%0d", press_tick, SAMPLES, SAMPLES + 1);
    end
  endtask

  task automatic test_glitch;
    int t0, pul, rel;
    bit stage_low, stage_high;
    pul = 0; rel = 0; stage_low = 1'b0; stage_high = 1'b0;
    t0 = m_ticks;
    for (int c = 0; c < 800 && m_ticks < t0 + 8; c++) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== exp_o) begin
        bad++; $display("FAIL glitch_cycle: outputs=%b want=%b", dut_o, exp_o);
      end
      if (bus.db_pulse) pul++;
      if (bus.db_release) rel++;
      if (!stage_low && m_ticks == t0 + 1) begin bus.btn_in = 1'b0; stage_low = 1'b1; end
      if (!stage_high && m_ticks == t0 + 2) begin bus.btn_in = 1'b1; stage_high = 1'b1; end
    end
    total++;
    if (pul != 0 || rel != 0 || bus.db_level !== 1'b1) begin
      bad++; $display("FAIL glitch_reject: pulse=%0d release=%0d level=%b want=0/0/1", pul, rel, bus.db_level);
    end
  endtask

  task automatic test_hold_repeat;
    int tp, rel_tick, rel;
    int got_off[$];
    int want_off[$];
    bit dropped, got;
`ifdef DEBOUNCE_REPEAT_EN
    want_off = '{0, RDELAY, RDELAY + RRATE, RDELAY + 2 * RRATE, RDELAY + 3 * RRATE};
`else
    want_off = '{0};
`endif
    bus.btn_in = 1'b1;
    got = 1'b0; tp = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== exp_o) begin
        bad++; $display("FAIL hold_cycle: outputs=%b want=%b", dut_o, exp_o);
      end
      if (bus.db_pulse) begin got = 1'b1; tp = m_ticks; got_off.push_back(0); end
    end
    dropped = 1'b0; rel = 0; rel_tick = -1;
    for (int c = 0; c < 1200 && got && m_ticks < tp + 26; c++) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== exp_o) begin
        bad++; $display("FAIL hold_cycle: outputs=%b want=%b", dut_o, exp_o);
      end
      if (bus.db_pulse) got_off.push_back(m_ticks - tp);
      if (bus.db_release) begin rel++; rel_tick = m_ticks - tp; end
      // Zeros sampled from offset 19 on put the release exactly on offset 22.
      if (!dropped && m_ticks == tp + 18) begin bus.btn_in = 1'b0; dropped = 1'b1; end
    end
    total++;
    if (got_off.size() != want_off.size()) begin
      bad++; $display("FAIL repeat_count: pulses=%0d want=%0d", got_off.size(), want_off.size());
    end else begin
      foreach (want_off[i]) begin
        total++;
        if (got_off[i] != want_off[i]) begin
          bad++; $display("FAIL repeat_offset[%0d]: tick=%0d want=%0d", i, got_off[i], want_off[i]);
        end
      end
    end
    total++;
    if (rel != 1 || rel_tick != 22) begin
      bad++; $display("FAIL repeat_release: count=%0d tick=%0d want=1/22", rel, rel_tick);
    end
  endtask

  task automatic test_reset_mid_hold;
    int t0, rel;
    bit got;
    bus.btn_in = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk_in);
      if (bus.db_level) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL midhold_press: level=%b want=1", bus.db_level);
    end
    repeat ($urandom_range(20, 80)) @(negedge clk_in);
    #3 reset = 1'b1;
    #1;
    total++;
    if (dut_o !== 3'b000) begin
      bad++; $display("FAIL midhold_async_clear: outputs=%b want=000", dut_o);
    end
    repeat (3) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== 3'b000) begin
        bad++; $display("FAIL midhold_in_reset: outputs=%b want=000", dut_o);
      end
    end
    reset = 1'b0;
    t0 = m_ticks; rel = 0; got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk_in);
      total++;
      if (dut_o !== exp_o) begin
        bad++; $display("FAIL midhold_cycle: outputs=%b want=%b", dut_o, exp_o);
      end
      if (bus.db_release) rel++;
      if (bus.db_pulse) begin
        got = 1'b1;
        total++;
        if (m_ticks - t0 != SAMPLES) begin
          bad++; $display("FAIL midhold_repress: ticks=%0d want=%0d", m_ticks - t0, SAMPLES);
        end
      end
    end
    total++;
    if (!got || rel != 0) begin
      bad++; $display("FAIL midhold_pulses: pulse_seen=%0d release=%0d want=1/0", got, rel);
    end
  endtask

  initial begin
    bus.btn_in = 1'b1;
    test_reset();
    test_release();
    test_bouncy_press();
    test_glitch();
    test_release();
    test_hold_repeat();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
